event_packetizer: RTL and testbench

EVENT_PACKETIZER -- requirements
Module: event_packetizer

---
 rtl/event_packetizer.sv | 97 +++++++++
 tb/tb_event_packetizer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/event_packetizer.sv
// Event packetizer: timestamps granted events into {pol, addr, timestamp} packets,
// buffers them in a first-word-fall-through FIFO, and counts drops and wallclock wraps.
module event_packetizer #(
   parameter int SIZE   = 32,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 8,
   localparam int PW    = SIZE + ADDR_W + 1,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [SIZE-1:0]   timestamp_i,
   input  logic              event_valid_i,
   input  logic [ADDR_W-1:0] event_addr_i,
   input  logic              event_pol_i,
   output logic              pkt_valid_o,
   output logic [PW-1:0]     pkt_data_o,
   input  logic              pkt_ready_i,
   output logic              fifo_full_o,
   output logic [LW-1:0]     level_o,
   output logic [15:0]       drop_cnt_o,
   output logic [15:0]       wrap_cnt_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PW-1:0]    mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;
   logic [15:0]      wrap_cnt_q, wrap_cnt_d;
   logic [SIZE-1:0]  prev_ts_q, prev_ts_d;
   logic             armed_q, armed_d;
   logic             full, empty, push, pop;

   always_comb begin
      full  = (level_q == LW'(DEPTH));
      empty = (level_q == '0);
      push  = event_valid_i && !full;
      pop   = !empty && pkt_ready_i;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      drop_cnt_d = drop_cnt_q;
      wrap_cnt_d = wrap_cnt_q;
      prev_ts_d  = timestamp_i;
      armed_d    = 1'b1;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);

      // A drop is decided on the pre-edge full flag, so a same-cycle pop does not rescue it.
      if (event_valid_i && full && drop_cnt_q != 16'hFFFF)
         drop_cnt_d = drop_cnt_q + 16'd1;

      if (armed_q && (timestamp_i < prev_ts_q))
         wrap_cnt_d = wrap_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         drop_cnt_q <= '0;
         wrap_cnt_q <= '0;
         prev_ts_q  <= '0;
         armed_q    <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         drop_cnt_q <= drop_cnt_d;
         wrap_cnt_q <= wrap_cnt_d;
         prev_ts_q  <= prev_ts_d;
         armed_q    <= armed_d;
      end
   end

   // Storage is never reset; the pointers and level alone define what is valid.
   always_ff @(posedge clk_i) begin
      if (push && !reset_i)
         mem[wr_ptr_q] <= {event_pol_i, event_addr_i, timestamp_i};
   end

   assign pkt_valid_o = !empty;
   assign pkt_data_o  = mem[rd_ptr_q];
   assign fifo_full_o = full;
   assign level_o     = level_q;
   assign drop_cnt_o  = drop_cnt_q;
   assign wrap_cnt_o  = wrap_cnt_q;

endmodule

// File: tb/tb_event_packetizer.sv
// Randomized and directed bench for event_packetizer with a queue-based reference
// model; a separate monitor compares every presented head packet against the scoreboard.
module tb_event_packetizer;

   localparam int SIZE   = 32;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 8;
   localparam int PW     = SIZE + ADDR_W + 1;
   localparam int LW     = $clog2(DEPTH) + 1;

   logic              clk_i = 1'b0;
   logic              reset_i = 1'b0;
   logic [SIZE-1:0]   timestamp_i = '0;
   logic              event_valid_i = 1'b0;
   logic [ADDR_W-1:0] event_addr_i = '0;
   logic              event_pol_i = 1'b0;
   logic              pkt_valid_o;
   logic [PW-1:0]     pkt_data_o;
   logic              pkt_ready_i = 1'b0;
   logic              fifo_full_o;
   logic [LW-1:0]     level_o;
   logic [15:0]       drop_cnt_o;
   logic [15:0]       wrap_cnt_o;

   event_packetizer #(.SIZE(SIZE), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .timestamp_i(timestamp_i),
      .event_valid_i(event_valid_i), .event_addr_i(event_addr_i), .event_pol_i(event_pol_i),
      .pkt_valid_o(pkt_valid_o), .pkt_data_o(pkt_data_o), .pkt_ready_i(pkt_ready_i),
      .fifo_full_o(fifo_full_o), .level_o(level_o), .drop_cnt_o(drop_cnt_o),
      .wrap_cnt_o(wrap_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad = 0;

   // Reference model state
   logic [PW-1:0] exp_q[$];
   int            m_level = 0;
   int            m_drops = 0;
   int            m_wraps = 0;
   logic [31:0]   m_prev = '0;
   bit            m_armed = 0;
   bit            release_pending = 0;
   logic [31:0]   ts = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, " level"}, 64'(level_o), 64'(m_level));
      check({tag, " full"},  64'(fifo_full_o), 64'(m_level == DEPTH));
      check({tag, " valid"}, 64'(pkt_valid_o), 64'(m_level != 0));
      check({tag, " drops"}, 64'(drop_cnt_o), 64'(m_drops));
      check({tag, " wraps"}, 64'(wrap_cnt_o), 64'(m_wraps));
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_level = 0;
      m_drops = 0;
      m_wraps = 0;
      m_armed = 0;
   endtask

   // One clock cycle: drive at negedge, apply the model rules at posedge, check after.
   task automatic cycle(input bit ev, input logic [7:0] a, input bit p,
                        input logic [31:0] t, input bit r, input string tag);
      bit will_pop, will_push, is_full;
      @(negedge clk_i);
      if (release_pending) begin
         reset_i = 1'b0;
         release_pending = 0;
      end
      event_valid_i = ev;
      event_addr_i  = a;
      event_pol_i   = p;
      timestamp_i   = t;
      pkt_ready_i   = r;
      is_full   = (m_level == DEPTH);
      will_pop  = (m_level > 0) && r;
      will_push = ev && !is_full;
      @(posedge clk_i);
      if (will_push) exp_q.push_back({p, a, t});
      m_level = m_level + int'(will_push) - int'(will_pop);
      if (ev && is_full && m_drops < 16'hFFFF) m_drops++;
      if (m_armed && t < m_prev) m_wraps = (m_wraps + 1) % 65536;
      m_prev  = t;
      m_armed = 1;
      #1;
      check_state(tag);
      $display("cycle %s ev=%0b addr=%0h pol=%0b ts=%0h rdy=%0b -> level=%0d drops=%0d wraps=%0d",
               tag, ev, a, p, t, r, level_o, drop_cnt_o, wrap_cnt_o);
   endtask

   // Monitor: whenever the DUT presents a head packet, it must match the scoreboard head.
   initial begin
      forever begin
         @(negedge clk_i);
         #2;
         if (pkt_valid_o) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL head: got %0h expected no packet at %0t", pkt_data_o, $time);
            end else begin
               check("head data", 64'(pkt_data_o), 64'(exp_q[0]));
               if (pkt_ready_i) void'(exp_q.pop_front());
            end
         end else begin
            check("head absent", 64'(exp_q.size()), 64'd0);
         end
      end
   end

   initial begin
      #1 reset_i = 1'b1;
      #1 check_state("reset");
      repeat (2) @(posedge clk_i);
      release_pending = 1;

      // Single event, then empty again one edge later
      cycle(1, 8'h2A, 1, 32'h0000_0100, 1, "single");
      check("single pkt", 64'(pkt_data_o), 64'({1'b1, 8'h2A, 32'h100}));
      cycle(0, 8'h00, 0, 32'h0000_0101, 1, "single-idle");

      // Fill with back-pressure: 10 events, 2 dropped, then drain
      ts = 32'h200;
      for (int i = 0; i < 10; i++) begin
         cycle(1, 8'(i + 1), i[0], ts, 0, "fill");
         ts++;
      end
      for (int i = 0; i < 8; i++) begin
         cycle(0, 8'h00, 0, ts, 1, "drain");
         ts++;
      end

      // Full with simultaneous push and pop: event dropped, level 7
      for (int i = 0; i < 8; i++) begin
         cycle(1, 8'(8'h40 + i), 1, ts, 0, "refill");
         ts++;
      end
      cycle(1, 8'h55, 0, ts, 1, "full-pushpop");
      ts++;
      for (int i = 0; i < 8; i++) begin
         cycle(0, 8'h00, 0, ts, 1, "drain2");
         ts++;
      end

      // Streaming at one per cycle
      for (int i = 0; i < 100; i++) begin
         cycle(1, 8'(i), i[1], ts, 1, "stream");
         ts++;
      end
      cycle(0, 8'h00, 0, ts, 1, "stream-end");

      // Timestamp wrap, then a normal step
      cycle(0, 8'h00, 0, 32'hFFFF_FFFF, 1, "wrap-pre");
      cycle(1, 8'h77, 1, 32'h0000_0000, 1, "wrap");
      cycle(0, 8'h00, 0, 32'h0000_0005, 1, "step5");
      cycle(0, 8'h00, 0, 32'h0000_0006, 1, "step6");
      ts = 32'h7;

      // Randomized traffic with occasional timestamp jumps
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) ts = $urandom();
         else ts++;
         cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
               ts, 1'($urandom_range(0, 2) != 0 ? 1 : ($urandom_range(0, 3) == 0)), "rand");
      end
      for (int i = 0; i < DEPTH; i++) begin
         ts++;
         cycle(0, 8'h00, 0, ts, 1, "rand-drain");
      end

      // Reset mid-stream with five packets stored
      for (int i = 0; i < 5; i++) begin
         ts++;
         cycle(1, 8'(8'h90 + i), 0, ts, 0, "pre-reset");
      end
      @(posedge clk_i);
      #3 reset_i = 1'b1;
      model_clear();
      #1 check_state("async-reset");
      @(posedge clk_i);
      release_pending = 1;
      ts++;
      cycle(1, 8'hC3, 1, ts, 0, "post-reset");
      check("post-reset sole", 64'(level_o), 64'd1);
      ts++;
      cycle(0, 8'h00, 0, ts, 1, "post-reset-pop");

      // Drop counter saturation: keep the FIFO full and keep offering events
      for (int i = 0; i < DEPTH; i++) begin
         ts++;
         cycle(1, 8'(i), 0, ts, 0, "sat-fill");
      end
      for (int i = 0; i < 65540; i++) begin
         @(negedge clk_i);
         event_valid_i = 1'b1;
         pkt_ready_i   = 1'b0;
         @(posedge clk_i);
         if (m_drops < 16'hFFFF) m_drops++;
      end
      #1;
      check("drop saturated", 64'(drop_cnt_o), 64'hFFFF);
      ts++;
      cycle(1, 8'h11, 0, ts, 1, "sat-pushpop");
      check("drop held", 64'(drop_cnt_o), 64'hFFFF);

      check("final occupancy", 64'(exp_q.size()), 64'(m_level));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
